// File: rtl/rec_fn_to_in_seq.sv
// Recoded binary64 to int64/uint64 converter: ALIGN then ROUND, result held in HOLD until taken.
// A new operand can be accepted on the same edge that the held result is consumed.
module rec_fn_to_in_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_in_valid,
   output logic        io_in_ready,
   input  logic [64:0] io_in,
   input  logic        io_signedOut,
   input  logic [1:0]  io_roundingMode,
   output logic        io_out_valid,
   input  logic        io_out_ready,
   output logic [63:0] io_out,
   output logic [4:0]  io_exceptionFlags
);

   typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ROUND, S_HOLD} state_t;
   typedef enum logic [1:0] {C_FIN, C_ZERO, C_NAN, C_SAT} cls_t;

   state_t        state_q, state_d;
   cls_t          cls_q, cls_d;
   logic [64:0]   in_q;
   logic          signed_q;
   logic [1:0]    rm_q;
   logic [63:0]   int_q, int_d;
   logic          guard_q, guard_d, sticky_q, sticky_d;
   logic [63:0]   out_q, out_d;
   logic [4:0]    flags_q, flags_d;
   logic          accept;

   assign io_in_ready       = (state_q == S_IDLE) | ((state_q == S_HOLD) & io_out_ready);
   assign accept            = io_in_valid & io_in_ready;
   assign io_out_valid      = (state_q == S_HOLD);
   assign io_out            = out_q;
   assign io_exceptionFlags = flags_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_ALIGN;
         S_ALIGN: state_d = S_ROUND;
         S_ROUND: state_d = S_HOLD;
         S_HOLD:  if (io_out_ready) state_d = accept ? S_ALIGN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Alignment: split the significand into integer part, guard bit and sticky.
   logic [11:0]        exp_w;
   logic [51:0]        frac_w;
   logic [52:0]        sig_w;
   logic signed [12:0] texp_w;
   logic [5:0]         rsh_w;
   logic [3:0]         lsh_w;
   logic [116:0]       shr_w;

   assign exp_w  = in_q[63:52];
   assign frac_w = in_q[51:0];
   assign sig_w  = {1'b1, frac_w};
   assign texp_w = $signed({1'b0, exp_w}) - 13'sd2048;
   assign rsh_w  = 6'(13'sd52 - texp_w);
   assign lsh_w  = 4'(texp_w - 13'sd52);
   assign shr_w  = {sig_w, 64'b0} >> rsh_w;

   always_comb begin
      int_d    = '0;
      guard_d  = 1'b0;
      sticky_d = 1'b0;
      cls_d    = C_FIN;
      if (exp_w[11:9] == 3'b000) begin
         cls_d = C_ZERO;
      end else if (exp_w[11:9] == 3'b110) begin
         cls_d = C_SAT;
      end else if (exp_w[11:9] == 3'b111) begin
         cls_d = C_NAN;
      end else if (texp_w < -13'sd1) begin
         sticky_d = 1'b1;
      end else if (texp_w == -13'sd1) begin
         guard_d  = 1'b1;
         sticky_d = |frac_w;
      end else if (texp_w <= 13'sd52) begin
         int_d    = {11'b0, shr_w[116:64]};
         guard_d  = shr_w[63];
         sticky_d = |shr_w[62:0];
      end else if (texp_w <= 13'sd63) begin
         int_d = {11'b0, sig_w} << lsh_w;
      end else begin
         cls_d = C_SAT;
      end
   end

   // Rounding and range check on a 65-bit magnitude so a carry out of bit 63 is visible.
   logic        sign_w, inexact_w, inc_w, in_range_w;
   logic [64:0] mag_w;
   logic [63:0] sat_w;

   assign sign_w    = in_q[64];
   assign inexact_w = guard_q | sticky_q;
   assign mag_w     = {1'b0, int_q} + {64'b0, inc_w};
   assign sat_w     = signed_q ? (sign_w ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF)
                               : (sign_w ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF);

   always_comb begin
      case (rm_q)
         2'd0:    inc_w = guard_q & (sticky_q | int_q[0]);
         2'd2:    inc_w = sign_w & inexact_w;
         2'd3:    inc_w = ~sign_w & inexact_w;
         default: inc_w = 1'b0;
      endcase
      if (signed_q) in_range_w = sign_w ? (mag_w <= 65'h0_8000_0000_0000_0000) : (mag_w[64:63] == 2'b00);
      else          in_range_w = sign_w ? (mag_w == 65'h0) : ~mag_w[64];
   end

   always_comb begin
      out_d   = '0;
      flags_d = '0;
      case (cls_q)
         C_ZERO: begin
            out_d   = '0;
            flags_d = '0;
         end
         C_NAN: begin
            out_d   = signed_q ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
            flags_d = 5'b10000;
         end
         C_SAT: begin
            out_d   = sat_w;
            flags_d = 5'b10000;
         end
         default: begin
            if (in_range_w) begin
               out_d   = (signed_q & sign_w) ? -mag_w[63:0] : mag_w[63:0];
               flags_d = {4'b0000, inexact_w};
            end else begin
               out_d   = sat_w;
               flags_d = 5'b10000;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         in_q     <= '0;
         signed_q <= 1'b0;
         rm_q     <= '0;
         int_q    <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         cls_q    <= C_FIN;
         out_q    <= '0;
         flags_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            in_q     <= io_in;
            signed_q <= io_signedOut;
            rm_q     <= io_roundingMode;
         end
         if (state_q == S_ALIGN) begin
            int_q    <= int_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            cls_q    <= cls_d;
         end
         if (state_q == S_ROUND) begin
            out_q   <= out_d;
            flags_q <= flags_d;
         end
      end
   end

endmodule

// File: tb/tb_rec_fn_to_in_seq.sv
// Bench for rec_fn_to_in_seq: directed and random operands scored against an arithmetic model.
module tb_rec_fn_to_in_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        io_in_valid = 1'b0;
   logic        io_in_ready;
   logic [64:0] io_in = '0;
   logic        io_signedOut = 1'b0;
   logic [1:0]  io_roundingMode = '0;
   logic        io_out_valid;
   logic        io_out_ready = 1'b0;
   logic [63:0] io_out;
   logic [4:0]  io_exceptionFlags;

   rec_fn_to_in_seq dut (
      .clk(clk), .reset(reset),
      .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
      .io_in(io_in), .io_signedOut(io_signedOut), .io_roundingMode(io_roundingMode),
      .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
      .io_out(io_out), .io_exceptionFlags(io_exceptionFlags)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] o;
      logic [4:0]  f;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   bit   rdy_rand = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Value = sig * 2^(e-2048-52); rounding decided by comparing the discarded remainder with one half.
   function automatic void model(input logic [64:0] op, input bit sgn, input logic [1:0] rm,
                                 output logic [63:0] o, output logic [4:0] f);
      logic               neg, big, exact, up, ok, above, tie, odd;
      logic [11:0]        e;
      logic [127:0]       sig, ip, rem, half, m;
      logic signed [129:0] val, smin, smax, umax;
      int                 texp, s;
      neg = op[64];
      e = op[63:52];
      sig = {75'b0, 1'b1, op[51:0]};
      big = 1'b0;
      o = '0;
      f = '0;
      smin = -(130'sd1 <<< 63);
      smax = (130'sd1 <<< 63) - 130'sd1;
      umax = (130'sd1 <<< 64) - 130'sd1;
      texp = e;
      texp = texp - 2048;
      if (e[11:9] == 3'b000) return;
      if (e[11:9] == 3'b111) begin
         o = sgn ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
         f = 5'b10000;
         return;
      end
      if (e[11:9] == 3'b110 || texp >= 64) big = 1'b1;
      else begin
         above = 1'b0; tie = 1'b0;
         if (texp >= 52) begin
            ip = sig << (texp - 52);
            exact = 1'b1;
         end else begin
            s = 52 - texp;
            if (s > 64) begin
               ip = '0;
               exact = 1'b0;
            end else begin
               ip = sig >> s;
               rem = sig - (ip << s);
               half = 128'd1 << (s - 1);
               exact = (rem == 0);
               above = (rem > half);
               tie = (rem == half);
            end
         end
         odd = ip[0];
         case (rm)
            2'd0: up = above | (tie & odd);
            2'd1: up = 1'b0;
            2'd2: up = neg & ~exact;
            default: up = ~neg & ~exact;
         endcase
         m = ip + {127'b0, up};
         val = neg ? -$signed({2'b00, m}) : $signed({2'b00, m});
         ok = sgn ? (val >= smin && val <= smax) : (val >= 0 && val <= umax);
         if (ok) begin
            o = val[63:0];
            f = {4'b0000, ~exact};
         end else big = 1'b1;
      end
      if (big) begin
         o = sgn ? (neg ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF)
                 : (neg ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF);
         f = 5'b10000;
      end
   endfunction

   function automatic logic [64:0] rand_op();
      logic [63:0] r;
      logic [51:0] fr;
      logic [11:0] e;
      r = {$urandom, $urandom};
      fr = r[51:0];
      if ($urandom_range(0, 2) == 0) fr = fr & ~((52'h1 << $urandom_range(0, 51)) - 52'h1);
      if ($urandom_range(0, 9) == 0) fr = '0;
      case ($urandom_range(0, 9))
         0: e = {3'b000, 9'($urandom)};
         1: e = {3'b110, 9'($urandom)};
         2: e = {3'b111, 9'($urandom)};
         3: e = 12'($urandom_range(12'h200, 12'h7FD));
         4: e = 12'($urandom_range(12'h840, 12'hBFF));
         default: e = 12'(2046 + $urandom_range(0, 70));
      endcase
      return {1'($urandom), e, fr};
   endfunction

   // Present an operand from posedge+1 and hold it until accepted; the expectation is queued
   // on the cycle the handshake is seen, and the inputs are scrambled afterwards.
   task automatic issue(input logic [64:0] op, input bit sgn, input logic [1:0] rm,
                        input bit push, input logic [63:0] eo, input logic [4:0] ef);
      bit acc;
      exp_t x;
      acc = 1'b0;
      io_in = op; io_signedOut = sgn; io_roundingMode = rm; io_in_valid = 1'b1;
      for (int c = 0; c < 100 && !acc; c++) begin
         @(negedge clk);
         if (io_in_ready) begin
            acc = 1'b1;
            if (push) begin
               x.o = eo; x.f = ef;
               q.push_back(x);
            end
         end
         @(posedge clk); #1;
      end
      io_in_valid = 1'b0;
      io_in = {1'($urandom), $urandom, $urandom};
      io_signedOut = 1'($urandom);
      io_roundingMode = 2'($urandom);
      if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
   endtask

   task automatic run_dir(input logic [64:0] op, input bit sgn, input logic [1:0] rm,
                          input logic [63:0] eo, input logic [4:0] ef);
      issue(op, sgn, rm, 1'b1, eo, ef);
   endtask

   task automatic run_rand();
      logic [64:0] op;
      bit          sgn;
      logic [1:0]  rm;
      logic [63:0] eo;
      logic [4:0]  ef;
      op = rand_op();
      sgn = 1'($urandom);
      rm = 2'($urandom);
      model(op, sgn, rm, eo, ef);
      issue(op, sgn, rm, 1'b1, eo, ef);
   endtask

   task automatic drain();
      for (int c = 0; c < 300 && q.size() > 0; c++) @(negedge clk);
      chk("drain_pending", 64'(q.size()), 64'd0);
   endtask

   initial forever begin
      @(posedge clk); #1;
      if (rdy_rand) io_out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: scores every completed output handshake and checks stability while stalled.
   initial begin
      bit          stall;
      logic [63:0] po;
      logic [4:0]  pf;
      exp_t        x;
      stall = 1'b0; po = '0; pf = '0;
      forever begin
         @(negedge clk);
         if (reset) stall = 1'b0;
         else begin
            if (stall) begin
               chk("stall_out_stable", io_out, po);
               chk("stall_flags_stable", 64'(io_exceptionFlags), 64'(pf));
            end
            if (io_out_valid && io_out_ready) begin
               if (q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
               else begin
                  x = q.pop_front();
                  chk("result", io_out, x.o);
                  chk("flags", 64'(io_exceptionFlags), 64'(x.f));
               end
            end
            stall = io_out_valid && !io_out_ready;
            po = io_out; pf = io_exceptionFlags;
         end
      end
   end

   initial begin
      logic [63:0] held;
      logic [4:0]  heldf;
      bit          seen;

      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(io_out_valid), 64'd0);
      chk("rst_in_ready", 64'(io_in_ready), 64'd1);
      chk("rst_out", io_out, 64'd0);
      chk("rst_flags", 64'(io_exceptionFlags), 64'd0);
      reset = 1'b0;
      @(posedge clk); #2;

      rdy_rand = 1'b1;
      run_dir(65'h0_8014000000000000, 1'b1, 2'd0, 64'd2, 5'b00001);
      run_dir(65'h0_8014000000000000, 1'b1, 2'd3, 64'd3, 5'b00001);
      run_dir(65'h0_8014000000000000, 1'b1, 2'd1, 64'd2, 5'b00001);
      run_dir(65'h1_8014000000000000, 1'b1, 2'd2, 64'hFFFF_FFFF_FFFF_FFFD, 5'b00001);
      run_dir(65'h1_8014000000000000, 1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 5'b00001);
      run_dir(65'h0_83F0000000000000, 1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 5'b10000);
      run_dir(65'h0_83F0000000000000, 1'b0, 2'd0, 64'h8000_0000_0000_0000, 5'b00000);
      run_dir(65'h1_8000000000000000, 1'b0, 2'd0, 64'h0, 5'b10000);
      run_dir(65'h1_E000000000000000, 1'b1, 2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 5'b10000);
      run_dir(65'h0_C000000000000000, 1'b0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'b10000);
      run_dir(65'h1_0000000000000000, 1'b1, 2'd2, 64'h0, 5'b00000);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         run_rand();
      end
      drain();

      // Stalled result, then completion and a new accept on the same edge.
      rdy_rand = 1'b0;
      @(posedge clk); #2;
      io_out_ready = 1'b0;
      run_dir(65'h0_8014000000000000, 1'b1, 2'd3, 64'd3, 5'b00001);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (io_out_valid) seen = 1'b1;
      end
      chk("hold_valid_seen", 64'(seen), 64'd1);
      held = io_out; heldf = io_exceptionFlags;
      io_in = 65'h1_8014000000000000; io_signedOut = 1'b1; io_roundingMode = 2'd0;
      io_in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); @(negedge clk);
         chk("hold_out", io_out, held);
         chk("hold_flags", 64'(io_exceptionFlags), 64'(heldf));
         chk("hold_in_ready", 64'(io_in_ready), 64'd0);
         chk("hold_valid", 64'(io_out_valid), 64'd1);
      end
      @(posedge clk); #1;
      io_out_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_in_ready", 64'(io_in_ready), 64'd1);
      q.push_back('{o: 64'hFFFF_FFFF_FFFF_FFFE, f: 5'b00001});
      @(posedge clk); #1;
      io_in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_align_valid", 64'(io_out_valid), 64'd0);
      chk("b2b_align_in_ready", 64'(io_in_ready), 64'd0);
      @(negedge clk);
      chk("b2b_round_valid", 64'(io_out_valid), 64'd0);
      chk("b2b_round_in_ready", 64'(io_in_ready), 64'd0);
      @(negedge clk);
      chk("b2b_hold_valid", 64'(io_out_valid), 64'd1);
      drain();

      // Reset while the operand sits in ROUND: nothing may come out afterwards.
      @(posedge clk); #1;
      io_out_ready = 1'b1;
      issue(65'h0_8014000000000000, 1'b1, 2'd3, 1'b0, 64'd0, 5'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(io_out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(io_in_ready), 64'd1);
      chk("mid_rst_out", io_out, 64'd0);
      chk("mid_rst_flags", 64'(io_exceptionFlags), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("no_ghost_valid", 64'(io_out_valid), 64'd0);
      end
      @(posedge clk); #1;
      run_dir(65'h0_8014000000000000, 1'b0, 2'd1, 64'd2, 5'b00001);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
